stopwatch_bcd: RTL and testbench

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

---
 rtl/stopwatch_bcd.sv | 132 +++++++++++++
 tb/tb_stopwatch_bcd.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by an asynchronous slow tick; IDLE/RUN/PAUSE control.
// Optional lap freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       btn_start,
   input  logic       btn_stop,
   input  logic       btn_clear,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic       running,
   output logic       wrap
`ifdef STOPWATCH_LAP_EN
   ,
   input  logic       btn_lap,
   output logic       lap_active
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   tick_q;
   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic [3:0]             sec_lo_q, sec_hi_q, min_lo_q, min_hi_q;
   logic                   wrap_q;
   logic                   inc;
   logic                   sl_max, sh_max, ml_max, mh_max;
   logic [15:0]            live;
   logic [15:0]            disp;

   // Tick pulse is registered so it lands SYNC_STAGES+1 cycles after the input rise.
   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   always_comb begin
      state_d = state_q;
      if (btn_clear) begin
         state_d = IDLE;
      end else if (btn_stop) begin
         if (state_q == RUN) state_d = PAUSE;
      end else if (btn_start) begin
         if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
      end
   end

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   assign inc    = tick_q && (state_q == RUN);
   assign sl_max = (sec_lo_q >= 4'd9);
   assign sh_max = (sec_hi_q >= 4'd5);
   assign ml_max = (min_lo_q >= 4'd9);
   assign mh_max = (min_hi_q >= 4'd5);

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         sec_lo_q <= '0;
         sec_hi_q <= '0;
         min_lo_q <= '0;
         min_hi_q <= '0;
         wrap_q   <= 1'b0;
      end else if (btn_clear) begin
         sec_lo_q <= '0;
         sec_hi_q <= '0;
         min_lo_q <= '0;
         min_hi_q <= '0;
         wrap_q   <= 1'b0;
      end else begin
         wrap_q <= inc && sl_max && sh_max && ml_max && mh_max;
         if (inc) begin
            sec_lo_q <= sl_max ? 4'd0 : sec_lo_q + 4'd1;
            if (sl_max)
               sec_hi_q <= sh_max ? 4'd0 : sec_hi_q + 4'd1;
            if (sl_max && sh_max)
               min_lo_q <= ml_max ? 4'd0 : min_lo_q + 4'd1;
            if (sl_max && sh_max && ml_max)
               min_hi_q <= mh_max ? 4'd0 : min_hi_q + 4'd1;
         end
      end
   end

   assign live = {min_hi_q, min_lo_q, sec_hi_q, sec_lo_q};

`ifdef STOPWATCH_LAP_EN
   logic        lap_q;
   logic [15:0] hold_q;

   // Freeze captures the pre-tick live value; counting carries on underneath.
   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         lap_q  <= 1'b0;
         hold_q <= '0;
      end else if (btn_clear) begin
         lap_q  <= 1'b0;
      end else if (btn_lap && state_q == RUN) begin
         lap_q <= ~lap_q;
         if (!lap_q) hold_q <= live;
      end
   end

   assign lap_active = lap_q;
   assign disp       = lap_q ? hold_q : live;
`else
   assign disp = live;
`endif

   assign {min_hi, min_lo, sec_hi, sec_lo} = disp;
   assign running = (state_q == RUN);
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: a seconds-integer reference model queues expected
// outputs per event; a negedge monitor compares every cycle.
module tb_stopwatch_bcd;
   localparam int S = 2;

   logic       clkin = 1'b0;
   logic       rst = 1'b1;
   logic       tick_in = 1'b0;
   logic       btn_start = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0;
   logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
   logic       running, wrap;
`ifdef STOPWATCH_LAP_EN
   logic       btn_lap = 1'b0;
   logic       lap_active;
`endif

   always #5 clkin = ~clkin;

   stopwatch_bcd #(.SYNC_STAGES(S)) dut (
      .clkin(clkin), .rst(rst), .tick_in(tick_in),
      .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
      .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
      .running(running), .wrap(wrap)
`ifdef STOPWATCH_LAP_EN
      , .btn_lap(btn_lap), .lap_active(lap_active)
`endif
   );

   typedef struct {
      int edge_n;
      int disp;
      bit run;
      bit wr;
      bit lap;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   tq[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 0;

   // reference model: elapsed seconds as a plain integer, mode 0=idle 1=run 2=pause
   int   m_secs = 0;
   int   m_mode = 0;
   int   m_hold = 0;
   bit   m_frz = 0;

   always @(posedge clkin) cyc <= cyc + 1;

   function automatic logic [15:0] bcd(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at cycle %0d", nm, act, req, cyc);
      end
   endtask

   always @(negedge clkin) begin
      exp_t e;
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].edge_n == cyc) begin
            e = sb.pop_front();
         end else begin
            e = last;
            e.wr = 1'b0;
         end
         last = e;
         chk("digits", {16'h0, min_hi, min_lo, sec_hi, sec_lo}, {16'h0, bcd(e.disp)});
         chk("running", {31'h0, running}, {31'h0, e.run});
         chk("wrap", {31'h0, wrap}, {31'h0, e.wr});
`ifdef STOPWATCH_LAP_EN
         chk("lap_active", {31'h0, lap_active}, {31'h0, e.lap});
`endif
      end
   end

   // Drive one cycle of inputs (called just after a posedge) and model the next edge.
   // tk: 0 hold tick_in, 1 raise, 2 lower.
   task automatic drive(input bit st, input bit sp, input bit cl, input bit lp, input int tk);
      int   e;
      bit   tick;
      bit   was_run;
      bit   w;
      exp_t x;
      e = cyc + 1;
      btn_start = st;
      btn_stop  = sp;
      btn_clear = cl;
`ifdef STOPWATCH_LAP_EN
      btn_lap = lp;
`endif
      if (tk == 1 && !tick_in) begin
         tick_in = 1'b1;
         tq.push_back(cyc + S + 2);
      end else if (tk == 2) begin
         tick_in = 1'b0;
      end
      tick = (tq.size() > 0 && tq[0] == e);
      if (tick) void'(tq.pop_front());
      was_run = (m_mode == 1);
      w = 1'b0;
      if (cl) begin
         m_mode = 0;
         m_secs = 0;
         m_frz  = 1'b0;
      end else begin
         if (lp && was_run) begin
            if (!m_frz) begin
               m_frz  = 1'b1;
               m_hold = m_secs;
            end else begin
               m_frz = 1'b0;
            end
         end
         if (tick && was_run) begin
            if (m_secs == 3599) begin
               m_secs = 0;
               w = 1'b1;
            end else begin
               m_secs++;
            end
         end
         if (sp) begin
            if (was_run) m_mode = 2;
         end else if (st && m_mode != 1) begin
            m_mode = 1;
         end
      end
      if (tick || st || sp || cl || lp) begin
         x.edge_n = e;
         x.disp   = m_frz ? m_hold : m_secs;
         x.run    = (m_mode == 1);
         x.wr     = w;
         x.lap    = m_frz;
         sb.push_back(x);
      end
      @(posedge clkin);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0, 0);
   endtask

   // One tick_in pulse; the buttons land on the same edge the tick takes effect.
   task automatic tick_evt(input bit st, input bit sp, input bit cl, input bit lp);
      drive(0, 0, 0, 0, 1);
      repeat (S) drive(0, 0, 0, 0, 0);
      drive(st, sp, cl, lp, 2);
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      mon_en = 0;
      #2;
      rst = 1'b0;
      #1;
      chk("rst_digits", {16'h0, min_hi, min_lo, sec_hi, sec_lo}, 32'h0);
      chk("rst_running", {31'h0, running}, 32'h0);
      chk("rst_wrap", {31'h0, wrap}, 32'h0);
      btn_start = 0; btn_stop = 0; btn_clear = 0;
`ifdef STOPWATCH_LAP_EN
      btn_lap = 0;
`endif
      m_secs = 0;
      m_mode = 0;
      m_frz  = 1'b0;
      tq.delete();
      sb.delete();
      last = '{edge_n: 0, disp: 0, run: 1'b0, wr: 1'b0, lap: 1'b0};
      @(posedge clkin);
      @(posedge clkin);
      #3;
      rst = 1'b1;
      @(posedge clkin);
      #1;
      mon_en = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   initial begin
      bit st, sp, cl, lp;
      int r;
      last = '{edge_n: 0, disp: 0, run: 1'b0, wr: 1'b0, lap: 1'b0};
      #1;
      rst = 1'b0;
      #1;
      chk("init_digits", {16'h0, min_hi, min_lo, sec_hi, sec_lo}, 32'h0);
      chk("init_running", {31'h0, running}, 32'h0);
      chk("init_wrap", {31'h0, wrap}, 32'h0);
      #10;
      rst = 1'b1;
      @(posedge clkin);
      #1;
      mon_en = 1;
      idle(3);

      // start and five ticks
      drive(1, 0, 0, 0, 0);
      repeat (5) tick_evt(0, 0, 0, 0);
      idle(2);

      // run up to 59:59, then rollover
      repeat (3594) tick_evt(0, 0, 0, 0);
      tick_evt(0, 0, 0, 0);
      idle(3);

      // stop coincident with tick at 00:09
      repeat (9) tick_evt(0, 0, 0, 0);
      tick_evt(0, 1, 0, 0);
      repeat (3) tick_evt(0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      tick_evt(0, 0, 0, 0);

      // pause at 01:23, then all three buttons together
      repeat (72) tick_evt(0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      drive(1, 1, 1, 0, 0);
      tick_evt(0, 0, 0, 0);
      idle(2);

      // clear coincident with tick
      drive(1, 0, 0, 0, 0);
      repeat (4) tick_evt(0, 0, 0, 0);
      tick_evt(0, 0, 1, 0);
      idle(2);

      // reset mid-run at 12:34 with tick_in held high across release
      drive(1, 0, 0, 0, 0);
      repeat (754) tick_evt(0, 0, 0, 0);
      idle(2);
      drive(0, 0, 0, 0, 1);
      do_reset();
      idle(S + 4);
      drive(0, 0, 0, 0, 2);
      idle(3);

`ifdef STOPWATCH_LAP_EN
      drive(1, 0, 0, 0, 0);
      repeat (20) tick_evt(0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      repeat (4) tick_evt(0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      idle(2);
`endif

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 9);
         st = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 5) == 0);
         cl = ($urandom_range(0, 11) == 0);
         lp = 1'b0;
`ifdef STOPWATCH_LAP_EN
         lp = ($urandom_range(0, 4) == 0);
`endif
         if (r < 6) tick_evt(st, sp, cl, lp);
         else       drive(st, sp, cl, lp, 0);
         idle($urandom_range(0, 2));
      end
      idle(S + 4);

      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
